// File: rtl/row_open_policy.sv
`default_nettype none
// ============================================================================
// Module      : row_open_policy
// Description : Per-bank open-row table, HIT/MISS/CONFLICT request tagging and
//               idle-timeout precharge request generation.
// Revision    : 1.0 - initial release
// ============================================================================
module row_open_policy #(
    parameter int BANKS        = 16,
    parameter int BANK_W       = 4,
    parameter int ROW_W        = 16,
    parameter int IDLE_TIMEOUT = 64,
    parameter int TO_W         = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic              req_write,
    output logic              cls_valid,
    input  logic              cls_ready,
    output logic [BANK_W-1:0] cls_bank,
    output logic [ROW_W-1:0]  cls_row,
    output logic              cls_write,
    output logic [1:0]        cls_type,
    input  logic              act_done,
    input  logic [BANK_W-1:0] act_bank,
    input  logic [ROW_W-1:0]  act_row,
    input  logic              pre_done,
    input  logic [BANK_W-1:0] pre_bank,
    input  logic              ref_done,
    output logic              pre_req_valid,
    output logic [BANK_W-1:0] pre_req_bank,
    input  logic              pre_req_ready
);

    localparam logic [1:0]      c_CLOSED     = 2'd0;
    localparam logic [1:0]      c_OPEN       = 2'd1;
    localparam logic [1:0]      c_PRE_PEND   = 2'd2;
    localparam logic [1:0]      c_HIT        = 2'b00;
    localparam logic [1:0]      c_MISS       = 2'b01;
    localparam logic [1:0]      c_CONFLICT   = 2'b10;
    localparam logic [TO_W-1:0] c_TIMEOUT    = TO_W'(IDLE_TIMEOUT);
    localparam bit              c_TIMEOUT_EN = (IDLE_TIMEOUT != 0);

    logic [1:0]        r_state [BANKS];
    logic [ROW_W-1:0]  r_row   [BANKS];
    logic [TO_W-1:0]   r_cnt   [BANKS];

    logic              r_cls_valid;
    logic [BANK_W-1:0] r_cls_bank;
    logic [ROW_W-1:0]  r_cls_row;
    logic              r_cls_write;
    logic              r_pre_valid;
    logic [BANK_W-1:0] r_pre_bank;

    logic              w_accept;
    logic              w_pre_hs;
    logic [BANKS-1:0]  w_act_hit, w_pre_hit, w_hs_hit, w_req_hit, w_held;
    logic [BANKS-1:0]  w_elig, w_kill;
    logic [1:0]        w_cls_state;
    logic [ROW_W-1:0]  w_cls_open_row;
    logic              w_any;
    logic [BANK_W-1:0] w_sel;
    logic              w_cur_ok;

    assign req_ready     = !r_cls_valid | cls_ready;
    assign w_accept      = req_valid & req_ready;
    assign w_pre_hs      = r_pre_valid & pre_req_ready;
    assign cls_valid     = r_cls_valid;
    assign cls_bank      = r_cls_bank;
    assign cls_row       = r_cls_row;
    assign cls_write     = r_cls_write;
    assign pre_req_valid = r_pre_valid;
    assign pre_req_bank  = r_pre_bank;

    // Strobe decode per bank; out-of-range bank indices match no bank.
    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            assign w_act_hit[b] = act_done & (act_bank == BANK_W'(b));
            assign w_pre_hit[b] = pre_done & (pre_bank == BANK_W'(b));
            assign w_hs_hit[b]  = w_pre_hs & (r_pre_bank == BANK_W'(b));
            assign w_req_hit[b] = w_accept & (req_bank == BANK_W'(b));
            assign w_held[b]    = r_cls_valid & (r_cls_bank == BANK_W'(b));
            assign w_elig[b]    = c_TIMEOUT_EN & (r_state[b] == c_OPEN) &
                                  (r_cnt[b] == c_TIMEOUT) & ~w_held[b];
            // Anything that will make the bank ineligible at the next edge.
            assign w_kill[b]    = ref_done | w_act_hit[b] | w_pre_hit[b] |
                                  w_hs_hit[b] | w_req_hit[b];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (rst) begin
                r_state[b] <= c_CLOSED;
                r_row[b]   <= '0;
                r_cnt[b]   <= '0;
            end else begin
                if (ref_done)
                    r_state[b] <= c_CLOSED;
                else if (w_act_hit[b]) begin
                    r_state[b] <= c_OPEN;
                    r_row[b]   <= act_row;
                end else if (w_pre_hit[b] && r_state[b] != c_CLOSED)
                    r_state[b] <= c_CLOSED;
                else if (w_hs_hit[b] && r_state[b] == c_OPEN)
                    r_state[b] <= c_PRE_PEND;

                if (w_act_hit[b] | w_req_hit[b] | w_held[b])
                    r_cnt[b] <= '0;
                else if (r_state[b] == c_OPEN && r_cnt[b] != c_TIMEOUT)
                    r_cnt[b] <= r_cnt[b] + TO_W'(1);
            end
        end
    end

    // Classification tracks the live table so stalled requests see ACT/PRE.
    always_comb begin
        w_cls_state    = c_CLOSED;
        w_cls_open_row = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (r_cls_bank == BANK_W'(b)) begin
                w_cls_state    = r_state[b];
                w_cls_open_row = r_row[b];
            end
        end
        if (w_cls_state == c_CLOSED)
            cls_type = c_MISS;
        else if (w_cls_state == c_OPEN && w_cls_open_row == r_cls_row)
            cls_type = c_HIT;
        else
            cls_type = c_CONFLICT;
    end

    always_comb begin
        w_any    = 1'b0;
        w_sel    = '0;
        w_cur_ok = 1'b0;
        for (int b = BANKS - 1; b >= 0; b--) begin
            if (w_elig[b] & ~w_kill[b]) begin
                w_any = 1'b1;
                w_sel = BANK_W'(b);
            end
        end
        for (int b = 0; b < BANKS; b++) begin
            if (r_pre_bank == BANK_W'(b))
                w_cur_ok = w_elig[b] & ~w_kill[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cls_valid <= 1'b0;
            r_cls_bank  <= '0;
            r_cls_row   <= '0;
            r_cls_write <= 1'b0;
        end else if (w_accept) begin
            r_cls_valid <= 1'b1;
            r_cls_bank  <= req_bank;
            r_cls_row   <= req_row;
            r_cls_write <= req_write;
        end else if (cls_ready) begin
            r_cls_valid <= 1'b0;
        end
    end

    // Pending request is held until handshake, or withdrawn once ineligible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_valid <= 1'b0;
            r_pre_bank  <= '0;
        end else if (r_pre_valid && !pre_req_ready) begin
            if (!w_cur_ok)
                r_pre_valid <= 1'b0;
        end else begin
            r_pre_valid <= w_any;
            if (w_any)
                r_pre_bank <= w_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_row_open_policy.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_open_policy
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a behavioural table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_open_policy;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_bank;
    logic [15:0] req_row;
    logic        cls_valid, cls_ready, cls_write;
    logic [3:0]  cls_bank;
    logic [15:0] cls_row;
    logic [1:0]  cls_type;
    logic        act_done, pre_done, ref_done;
    logic [3:0]  act_bank, pre_bank;
    logic [15:0] act_row;
    logic        pre_req_valid, pre_req_ready;
    logic [3:0]  pre_req_bank;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    row_open_policy #(
        .BANKS(16), .BANK_W(4), .ROW_W(16), .IDLE_TIMEOUT(64), .TO_W(7)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_bank(req_bank),
        .req_row(req_row), .req_write(req_write),
        .cls_valid(cls_valid), .cls_ready(cls_ready), .cls_bank(cls_bank),
        .cls_row(cls_row), .cls_write(cls_write), .cls_type(cls_type),
        .act_done(act_done), .act_bank(act_bank), .act_row(act_row),
        .pre_done(pre_done), .pre_bank(pre_bank), .ref_done(ref_done),
        .pre_req_valid(pre_req_valid), .pre_req_bank(pre_req_bank),
        .pre_req_ready(pre_req_ready)
    );

    typedef struct {
        logic        rv;  logic [3:0] rb; logic [15:0] rr; logic rw;
        logic        cr;
        logic        ad;  logic [3:0] ab; logic [15:0] ar;
        logic        ev;  logic [3:0] eb; logic [15:0] er; logic ew;
        logic [1:0]  et;  logic erdy;
    } vec_t;

    vec_t tbl[12];

    // Behavioural model state for the random phase
    bit          m_open [16];
    logic [15:0] m_row  [16];
    bit          m_v;
    logic [3:0]  m_b;
    logic [15:0] m_r;
    logic        m_w;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_bank = '0; req_row = '0; req_write = 1'b0;
        cls_ready = 1'b1;
        act_done = 1'b0; act_bank = '0; act_row = '0;
        pre_done = 1'b0; pre_bank = '0; ref_done = 1'b0;
        pre_req_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic req(input logic [3:0] b, input logic [15:0] r);
        req_valid = 1'b1; req_bank = b; req_row = r; req_write = 1'b0;
    endtask

    task automatic wait_pre(input int budget, output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!pre_req_valid && k < budget);
    endtask

    initial begin
        int k;
        int seen;
        rst = 1'b0;

        tbl[0]  = '{1'b1,4'd3,16'h12,1'b0, 1'b1, 1'b0,4'd0,16'h0,  1'b1,4'd3,16'h12,1'b0,2'b01,1'b1};
        tbl[1]  = '{1'b0,4'd0,16'h0, 1'b0, 1'b1, 1'b1,4'd3,16'h12, 1'b0,4'd0,16'h0, 1'b0,2'b00,1'b1};
        tbl[2]  = '{1'b1,4'd3,16'h12,1'b0, 1'b1, 1'b0,4'd0,16'h0,  1'b1,4'd3,16'h12,1'b0,2'b00,1'b1};
        tbl[3]  = '{1'b1,4'd3,16'h40,1'b1, 1'b1, 1'b0,4'd0,16'h0,  1'b1,4'd3,16'h40,1'b1,2'b10,1'b1};
        tbl[4]  = '{1'b1,4'd6,16'h77,1'b0, 1'b1, 1'b0,4'd0,16'h0,  1'b1,4'd6,16'h77,1'b0,2'b01,1'b1};
        tbl[5]  = '{1'b1,4'd9,16'h55,1'b0, 1'b0, 1'b0,4'd0,16'h0,  1'b1,4'd6,16'h77,1'b0,2'b01,1'b0};
        tbl[6]  = '{1'b1,4'd9,16'h55,1'b0, 1'b0, 1'b0,4'd0,16'h0,  1'b1,4'd6,16'h77,1'b0,2'b01,1'b0};
        tbl[7]  = '{1'b1,4'd9,16'h55,1'b0, 1'b0, 1'b1,4'd6,16'h77, 1'b1,4'd6,16'h77,1'b0,2'b00,1'b0};
        tbl[8]  = '{1'b1,4'd9,16'h55,1'b0, 1'b0, 1'b0,4'd0,16'h0,  1'b1,4'd6,16'h77,1'b0,2'b00,1'b0};
        tbl[9]  = '{1'b1,4'd9,16'h55,1'b0, 1'b0, 1'b0,4'd0,16'h0,  1'b1,4'd6,16'h77,1'b0,2'b00,1'b0};
        tbl[10] = '{1'b1,4'd9,16'h55,1'b0, 1'b1, 1'b0,4'd0,16'h0,  1'b1,4'd9,16'h55,1'b0,2'b01,1'b1};
        tbl[11] = '{1'b0,4'd0,16'h0, 1'b0, 1'b1, 1'b0,4'd0,16'h0,  1'b0,4'd0,16'h0, 1'b0,2'b00,1'b1};

        // Reset state
        do_reset();
        chk("rst_cls_valid", cls_valid, 0);
        chk("rst_pre_valid", pre_req_valid, 0);
        chk("rst_cls_bank", cls_bank, 0);
        chk("rst_cls_row", cls_row, 0);
        chk("rst_cls_write", cls_write, 0);
        chk("rst_req_ready", req_ready, 1);

        // Vector table: MISS, ACT, HIT, CONFLICT, stall with ACT flip
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].rv; req_bank = tbl[i].rb; req_row = tbl[i].rr;
            req_write = tbl[i].rw; cls_ready = tbl[i].cr;
            act_done = tbl[i].ad; act_bank = tbl[i].ab; act_row = tbl[i].ar;
            tick();
            chk($sformatf("tbl%0d_cls_valid", i), cls_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].erdy);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_cls_bank", i), cls_bank, tbl[i].eb);
                chk($sformatf("tbl%0d_cls_row", i), cls_row, tbl[i].er);
                chk($sformatf("tbl%0d_cls_write", i), cls_write, tbl[i].ew);
                chk($sformatf("tbl%0d_cls_type", i), cls_type, tbl[i].et);
            end
        end

        // Idle timeout on bank 5, handshake, no repeat, then PRE_PEND / close
        do_reset();
        act_done = 1'b1; act_bank = 4'd5; act_row = 16'h100;
        tick();
        act_done = 1'b0;
        wait_pre(80, k);
        chk("to_cycle", k, 65);
        chk("to_bank", pre_req_bank, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold_valid", pre_req_valid, 1);
            chk("to_hold_bank", pre_req_bank, 5);
        end
        pre_req_ready = 1'b1;
        tick();
        pre_req_ready = 1'b0;
        chk("to_after_hs", pre_req_valid, 0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (pre_req_valid) seen++;
        end
        chk("to_no_repeat", seen, 0);
        req(4'd5, 16'h100);
        tick();
        chk("prepend_type", cls_type, 2'b10);
        req_valid = 1'b0;
        pre_done = 1'b1; pre_bank = 4'd5;
        tick();
        pre_done = 1'b0;
        req(4'd5, 16'h100);
        tick();
        req_valid = 1'b0;
        chk("closed_valid", cls_valid, 1);
        chk("closed_type", cls_type, 2'b01);

        // Banks 2 and 7 time out together: lowest index first
        do_reset();
        act_done = 1'b1; act_bank = 4'd2; act_row = 16'h22;
        req(4'd2, 16'h22);
        tick();
        req_valid = 1'b0;
        act_bank = 4'd7; act_row = 16'h77;
        tick();
        act_done = 1'b0;
        wait_pre(80, k);
        chk("arb_cycle", k, 65);
        chk("arb_first", pre_req_bank, 2);
        pre_req_ready = 1'b1;
        tick();
        pre_req_ready = 1'b0;
        chk("arb_second_valid", pre_req_valid, 1);
        chk("arb_second_bank", pre_req_bank, 7);
        pre_req_ready = 1'b1;
        tick();
        pre_req_ready = 1'b0;
        chk("arb_done", pre_req_valid, 0);

        // ref_done with open banks and a pending precharge request
        do_reset();
        act_done = 1'b1; act_bank = 4'd4; act_row = 16'h1;
        tick();
        act_bank = 4'd8; act_row = 16'h2;
        tick();
        act_done = 1'b0;
        wait_pre(80, k);
        chk("ref_pre_seen", pre_req_valid, 1);
        chk("ref_pre_bank", pre_req_bank, 4);
        ref_done = 1'b1;
        tick();
        ref_done = 1'b0;
        chk("ref_pre_drop", pre_req_valid, 0);
        tick();
        chk("ref_pre_stay", pre_req_valid, 0);
        req(4'd4, 16'h1);
        tick();
        chk("ref_b4_type", cls_type, 2'b01);
        req(4'd8, 16'h2);
        tick();
        req_valid = 1'b0;
        chk("ref_b8_type", cls_type, 2'b01);
        chk("ref_b8_bank", cls_bank, 8);

        // Reset while stalled
        tick();
        req(4'd4, 16'h1);
        tick();
        req(4'd9, 16'h3);
        cls_ready = 1'b0;
        tick();
        act_done = 1'b1; act_bank = 4'd4; act_row = 16'h1;
        tick();
        act_done = 1'b0;
        chk("stall_hit", cls_type, 2'b00);
        chk("stall_ready", req_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_cls_valid", cls_valid, 0);
        chk("rstmid_pre_valid", pre_req_valid, 0);
        chk("rstmid_ready", req_ready, 1);
        cls_ready = 1'b1;
        req(4'd4, 16'h1);
        tick();
        req_valid = 1'b0;
        chk("rstmid_type", cls_type, 2'b01);
        chk("rstmid_bank", cls_bank, 4);

        // Randomized traffic against the behavioural table model
        do_reset();
        for (int b = 0; b < 16; b++) begin
            m_open[b] = 1'b0;
            m_row[b]  = '0;
        end
        m_v = 1'b0; m_b = '0; m_r = '0; m_w = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] exp_t;
            req_valid = ($urandom_range(0, 3) != 0);
            req_bank  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 3));
            req_row   = 16'($urandom_range(0, 2));
            req_write = 1'($urandom_range(0, 1));
            cls_ready = ($urandom_range(0, 3) != 0);
            act_done  = ($urandom_range(0, 7) == 0);
            act_bank  = 4'($urandom_range(0, 3));
            act_row   = 16'($urandom_range(0, 2));
            pre_done  = ($urandom_range(0, 7) == 0);
            pre_bank  = 4'($urandom_range(0, 3));
            ref_done  = ($urandom_range(0, 63) == 0);

            if (req_valid && (!m_v || cls_ready)) begin
                m_v = 1'b1; m_b = req_bank; m_r = req_row; m_w = req_write;
            end else if (cls_ready) begin
                m_v = 1'b0;
            end
            if (ref_done) begin
                for (int b = 0; b < 16; b++) m_open[b] = 1'b0;
            end else begin
                if (pre_done) m_open[pre_bank] = 1'b0;
                if (act_done) begin
                    m_open[act_bank] = 1'b1;
                    m_row[act_bank]  = act_row;
                end
            end

            tick();
            chk("rnd_cls_valid", cls_valid, m_v);
            chk("rnd_req_ready", req_ready, !m_v || cls_ready);
            if (m_v) begin
                exp_t = !m_open[m_b] ? 2'b01 : (m_row[m_b] == m_r ? 2'b00 : 2'b10);
                chk("rnd_cls_bank", cls_bank, m_b);
                chk("rnd_cls_row", cls_row, m_r);
                chk("rnd_cls_write", cls_write, m_w);
                chk("rnd_cls_type", cls_type, exp_t);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
